// File: rtl/chain_relax_core.sv
// Chain relaxation core: NODES 2-D positions smoothed by one shared Gauss-Seidel datapath.
// Optional macro CHAIN_CLAMP_EN saturates every node write to [0,X_MAX] x [0,Y_MAX].
module chain_relax_core #(
    parameter int NODES      = 5,
    parameter int COORD_W    = 32,
    parameter int ITER_W     = 4,
    parameter int BASE_INDEX = 0,
    parameter int SPACING    = 10,
    parameter int HAS_PREV   = 0,
    parameter int X_MAX      = 1023,
    parameter int Y_MAX      = 767
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ITER_W-1:0]           iters,
    input  logic signed [COORD_W-1:0]   target_x,
    input  logic signed [COORD_W-1:0]   target_y,
    input  logic signed [COORD_W-1:0]   prev_x,
    input  logic signed [COORD_W-1:0]   prev_y,
    input  logic signed [COORD_W-1:0]   next_x,
    input  logic signed [COORD_W-1:0]   next_y,
    input  logic                        next_valid,
    output logic                        busy,
    output logic                        done,
    output logic [NODES*COORD_W-1:0]    nodes_x,
    output logic [NODES*COORD_W-1:0]    nodes_y
);
    localparam int IDX_W = $clog2(NODES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NODES - 1);
    localparam logic [IDX_W-1:0] IDX_START = IDX_W'((HAS_PREV != 0) ? 0 : 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELAX, S_DONE} state_t;
    state_t state;

    logic signed [COORD_W-1:0] px [NODES];
    logic signed [COORD_W-1:0] py [NODES];
    logic signed [COORD_W-1:0] prev_xh, prev_yh, next_xh, next_yh;
    logic                      next_vh;
    logic [ITER_W-1:0]         pass_cnt;
    logic [IDX_W-1:0]          idx;

    // Widened sum then arithmetic shift, so negative averages floor toward -inf.
    function automatic logic signed [COORD_W-1:0] smooth(
        input logic signed [COORD_W-1:0] l,
        input logic signed [COORD_W-1:0] s,
        input logic signed [COORD_W-1:0] r,
        input logic                      tail
    );
        logic signed [COORD_W+1:0] l2, s2, r2, sum, avg;
        l2 = {{2{l[COORD_W-1]}}, l};
        s2 = {{2{s[COORD_W-1]}}, s};
        r2 = {{2{r[COORD_W-1]}}, r};
        if (tail) begin
            sum = l2 + s2;
            avg = sum >>> 1;
        end else begin
            sum = l2 + (s2 <<< 1) + r2;
            avg = sum >>> 2;
        end
        return avg[COORD_W-1:0];
    endfunction

`ifdef CHAIN_CLAMP_EN
    localparam logic signed [COORD_W-1:0] X_HI = COORD_W'(X_MAX);
    localparam logic signed [COORD_W-1:0] Y_HI = COORD_W'(Y_MAX);

    function automatic logic signed [COORD_W-1:0] bound_x(input logic signed [COORD_W-1:0] v);
        if (v < 0)         return '0;
        else if (v > X_HI) return X_HI;
        else               return v;
    endfunction

    function automatic logic signed [COORD_W-1:0] bound_y(input logic signed [COORD_W-1:0] v);
        if (v < 0)         return '0;
        else if (v > Y_HI) return Y_HI;
        else               return v;
    endfunction
`else
    function automatic logic signed [COORD_W-1:0] bound_x(input logic signed [COORD_W-1:0] v);
        return v;
    endfunction

    function automatic logic signed [COORD_W-1:0] bound_y(input logic signed [COORD_W-1:0] v);
        return v;
    endfunction
`endif

    logic [IDX_W-1:0]          lidx, ridx;
    logic signed [COORD_W-1:0] left_x, left_y, right_x, right_y, new_x, new_y;
    logic                      tail;

    // Neighbour indices are held in range at the ends; the halo mux selects there instead.
    always_comb begin
        lidx    = (idx == '0) ? idx : idx - IDX_W'(1);
        ridx    = (idx == IDX_LAST) ? idx : idx + IDX_W'(1);
        left_x  = (idx == '0) ? prev_xh : px[lidx];
        left_y  = (idx == '0) ? prev_yh : py[lidx];
        right_x = (idx == IDX_LAST) ? next_xh : px[ridx];
        right_y = (idx == IDX_LAST) ? next_yh : py[ridx];
        tail    = (idx == IDX_LAST) && !next_vh;
        new_x   = bound_x(smooth(left_x, px[idx], right_x, tail));
        new_y   = bound_y(smooth(left_y, py[idx], right_y, tail));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_cnt <= '0;
            idx      <= '0;
            prev_xh  <= '0;
            prev_yh  <= '0;
            next_xh  <= '0;
            next_yh  <= '0;
            next_vh  <= 1'b0;
            for (int k = 0; k < NODES; k++) begin
                px[k] <= COORD_W'((BASE_INDEX + k) * SPACING);
                py[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    prev_xh  <= prev_x;
                    prev_yh  <= prev_y;
                    next_xh  <= next_x;
                    next_yh  <= next_y;
                    next_vh  <= next_valid;
                    pass_cnt <= (iters == '0) ? ITER_W'(1) : iters;
                    if (HAS_PREV == 0) begin
                        px[0] <= bound_x(target_x);
                        py[0] <= bound_y(target_y);
                    end
                    idx   <= IDX_START;
                    state <= S_RELAX;
                end
                S_RELAX: begin
                    px[idx] <= new_x;
                    py[idx] <= new_y;
                    if (idx == IDX_LAST) begin
                        if (pass_cnt > ITER_W'(1)) begin
                            pass_cnt <= pass_cnt - ITER_W'(1);
                            idx      <= IDX_START;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NODES; g++) begin : g_out
        assign nodes_x[g*COORD_W +: COORD_W] = px[g];
        assign nodes_y[g*COORD_W +: COORD_W] = py[g];
    end
endmodule

// File: tb/tb_chain_relax_core.sv
// Bench for chain_relax_core (NODES=4, COORD_W=16, head core): directed cases plus
// randomized runs against a pass-by-pass arithmetic model of the chain.
module tb_chain_relax_core;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 4;
    localparam int XM = 100;
    localparam int YM = 767;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [IW-1:0]        iters;
    logic signed [W-1:0]  target_x, target_y, prev_x, prev_y, next_x, next_y;
    logic                 next_valid;
    logic                 busy, done;
    logic [N*W-1:0]       nodes_x, nodes_y;

    chain_relax_core #(
        .NODES(N), .COORD_W(W), .ITER_W(IW), .BASE_INDEX(0), .SPACING(10),
        .HAS_PREV(0), .X_MAX(XM), .Y_MAX(YM)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .iters(iters),
        .target_x(target_x), .target_y(target_y),
        .prev_x(prev_x), .prev_y(prev_y),
        .next_x(next_x), .next_y(next_y), .next_valid(next_valid),
        .busy(busy), .done(done), .nodes_x(nodes_x), .nodes_y(nodes_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mx [N];
    int my [N];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int nx(input int k);
        return int'($signed(nodes_x[k*W +: W]));
    endfunction

    function automatic int ny(input int k);
        return int'($signed(nodes_y[k*W +: W]));
    endfunction

    function automatic int fdiv(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int lim(input int v, input int hi);
`ifdef CHAIN_CLAMP_EN
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
`else
        return v + 0 * hi;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mx[k] = k * 10;
            my[k] = 0;
        end
    endtask

    // Gauss-Seidel: each node is averaged with already-updated left neighbour.
    task automatic model_run(input int tx, input int ty, input int it, input int nv,
                             input int hx, input int hy);
        int passes;
        passes = (it == 0) ? 1 : it;
        mx[0] = lim(tx, XM);
        my[0] = lim(ty, YM);
        for (int p = 0; p < passes; p++) begin
            for (int k = 1; k < N; k++) begin
                if (k == N - 1 && nv == 0) begin
                    mx[k] = lim(fdiv(mx[k-1] + mx[k], 2), XM);
                    my[k] = lim(fdiv(my[k-1] + my[k], 2), YM);
                end else begin
                    mx[k] = lim(fdiv(mx[k-1] + 2 * mx[k] + ((k == N - 1) ? hx : mx[k+1]), 4), XM);
                    my[k] = lim(fdiv(my[k-1] + 2 * my[k] + ((k == N - 1) ? hy : my[k+1]), 4), YM);
                end
            end
        end
    endtask

    task automatic check_nodes(input string tag);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_x%0d", tag, k), nx(k), mx[k]);
            check($sformatf("%s_y%0d", tag, k), ny(k), my[k]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // One solve run; optionally pulses start mid-run and scrambles the inputs after LOAD.
    task automatic run(input string tag, input int tx, input int ty, input int it,
                       input int nv, input int hx, input int hy, input bit poke);
        int n;
        bit got;
        @(negedge clk);
        target_x = W'(tx);  target_y = W'(ty);
        iters = IW'(it);    next_valid = nv[0];
        next_x = W'(hx);    next_y = W'(hy);
        prev_x = W'($urandom_range(0, 500));
        prev_y = W'($urandom_range(0, 500));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        model_run(tx, ty, it, nv, hx, hy);
        n = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(posedge clk);
            #1 n++;
            if (n == 1) begin
                target_x = W'($urandom_range(0, 300));
                next_x = W'($urandom_range(0, 300));
                next_y = W'($urandom_range(0, 300));
                next_valid = $urandom_range(0, 1);
                iters = IW'($urandom_range(0, 15));
            end
            if (poke && n == 2) start = 1'b1;
            if (poke && n == 3) start = 1'b0;
            if (done) got = 1'b1;
            else check({tag, "_busy"}, busy, 1);
        end
        check({tag, "_latency"}, n, 1 + ((it == 0) ? 1 : it) * (N - 1));
        check({tag, "_busy_at_done"}, busy, 0);
        @(posedge clk);
        #1 check({tag, "_done_width"}, done, 0);
        check_nodes(tag);
        if (poke) begin
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1 check({tag, "_no_second_done"}, done, 0);
            end
            check_nodes({tag, "_after"});
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; iters = '0;
        target_x = '0; target_y = '0; prev_x = '0; prev_y = '0;
        next_x = '0; next_y = '0; next_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_nodes("reset");
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        reset = 1'b1;

        run("basic", 0, 40, 1, 0, 0, 0, 1'b0);
        check("basic_n1x", nx(1), 10);
        check("basic_n2y", ny(2), 2);
        check("basic_n3x", nx(3), 25);
        check("basic_n3y", ny(3), 1);

        do_reset();
        run("neg", -8, -3, 1, 0, 0, 0, 1'b0);
`ifndef CHAIN_CLAMP_EN
        check("neg_n0x", nx(0), -8);
        check("neg_n0y", ny(0), -3);
        check("neg_n1x", nx(1), 8);
        check("neg_n1y", ny(1), -1);
`endif

        do_reset();
        run("iters0", 0, 40, 0, 0, 0, 0, 1'b1);
        check("iters0_n3x", nx(3), 25);

        // Reset in the second RELAX cycle aborts the run with no done pulse.
        @(negedge clk);
        target_x = W'(77); target_y = W'(55); iters = IW'(3); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 model_reset();
        check_nodes("midrst");
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 check("midrst_no_done", done, 0);
        end

        run("clamp", 150, -5, 1, 0, 0, 0, 1'b0);
`ifdef CHAIN_CLAMP_EN
        check("clamp_n0x", nx(0), 100);
        check("clamp_n0y", ny(0), 0);
`else
        check("clamp_n0x", nx(0), 150);
        check("clamp_n0y", ny(0), -5);
`endif

        for (int r = 0; r < 20; r++) begin
            run($sformatf("rnd%0d", r),
                int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
